// File: rtl/adder_pkg.sv
// Shared definitions for the serial carry-lookahead adder: slice width,
// sequencer states and the slice-counter width helper.
package adder_pkg;

    localparam int CLA_SLICE_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A one-slice adder still needs a one-bit counter so idx is never zero-width.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/serial_cla_adder_cla.sv
// Purely combinational 5-bit carry-lookahead slice: every carry is formed
// directly from generate/propagate terms and the slice carry-in.
module cla
    import adder_pkg::*;
(
    input  logic [CLA_SLICE_W-1:0] a_i,
    input  logic [CLA_SLICE_W-1:0] b_i,
    input  logic                   cin_i,
    output logic [CLA_SLICE_W-1:0] sum_o,
    output logic                   cout_o
);

    logic [CLA_SLICE_W-1:0] g_s;
    logic [CLA_SLICE_W-1:0] p_s;
    logic [CLA_SLICE_W:0]   c_s;

    assign g_s = a_i & b_i;
    assign p_s = a_i ^ b_i;

    assign c_s[0] = cin_i;
    assign c_s[1] = g_s[0]
                  | (p_s[0] & c_s[0]);
    assign c_s[2] = g_s[1]
                  | (p_s[1] & g_s[0])
                  | (p_s[1] & p_s[0] & c_s[0]);
    assign c_s[3] = g_s[2]
                  | (p_s[2] & g_s[1])
                  | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign c_s[4] = g_s[3]
                  | (p_s[3] & g_s[2])
                  | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign c_s[5] = g_s[4]
                  | (p_s[4] & g_s[3])
                  | (p_s[4] & p_s[3] & g_s[2])
                  | (p_s[4] & p_s[3] & p_s[2] & g_s[1])
                  | (p_s[4] & p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[4] & p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

    assign sum_o  = p_s ^ c_s[CLA_SLICE_W-1:0];
    assign cout_o = c_s[CLA_SLICE_W];

endmodule

// File: rtl/serial_cla_adder.sv
// Wide adder that streams operands through one 5-bit CLA slice per clock,
// carrying between slices through a registered carry.
module serial_cla_adder
    import adder_pkg::*;
#(
    parameter  int NSLICE = 4,
    localparam int WIDTH  = CLA_SLICE_W * NSLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int             IDX_W    = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;

    logic [CLA_SLICE_W-1:0] slice_sum_s;
    logic                   slice_cout_s;

    // Operands shift right each RUN cycle, so the active slice is always the low bits.
    cla u_cla (
        .a_i    (a_q[CLA_SLICE_W-1:0]),
        .b_i    (b_q[CLA_SLICE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum_s),
        .cout_o (slice_cout_s)
    );

    // Sequencer next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> CLA_SLICE_W;
                b_d     = b_q >> CLA_SLICE_W;
                carry_d = slice_cout_s;
                cout_d  = slice_cout_s;
                sum_d[CLA_SLICE_W * int'(idx_q) +: CLA_SLICE_W] = slice_sum_s;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    state_d = RUN;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, operand, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_serial_cla_adder.sv
// Scoreboard bench for serial_cla_adder: the driver queues arithmetic
// expectations, an independent monitor checks every presented result.
module tb_serial_cla_adder;

    localparam int NSLICE = 4;
    localparam int WIDTH  = 5 * NSLICE;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   bp_en = 1'b0;

    serial_cla_adder #(.NSLICE(NSLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        bit   acc;
        int   n;
        exp_t e;
        logic [WIDTH:0] full;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
            e.sum = full[WIDTH-1:0];
            e.cout = full[WIDTH];
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 32'd0);
    endtask

    // Monitor: compare every DONE cycle against the queue head, pop on handshake.
    initial begin
        bit prev_valid;
        bit prev_hs;
        prev_valid = 1'b0;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (prev_hs) begin
                    chk("post_hs_valid_low", out_valid, 32'd0);
                    chk("post_hs_in_ready", in_ready, 32'd1);
                end
                if (out_valid === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out_valid", out_valid, 32'd0);
                    end else begin
                        if (!prev_valid) chk("latency", cyc - sb_q[0].acc_cyc, NSLICE);
                        chk("sum", out_sum, sb_q[0].sum);
                        chk("cout", out_cout, sb_q[0].cout);
                        chk("in_ready_in_done", in_ready, 32'd0);
                        if (out_ready) void'(sb_q.pop_front());
                    end
                end
                prev_hs = (out_valid === 1'b1) && out_ready;
                prev_valid = (out_valid === 1'b1);
            end else begin
                prev_hs = 1'b0;
                prev_valid = 1'b0;
            end
        end
    end

    // Random consumer backpressure.
    initial forever begin
        @(posedge clk); #1;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        int n;
        // Reset asserted and released mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_cout", out_cout, 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 32'd1);
        chk("post_rst_out_valid", out_valid, 32'd0);
        chk("post_rst_out_sum", out_sum, 32'd0);

        issue(20'h12345, 20'h0ABCD, 1'b0);
        drain();
        issue(20'hFFFFF, 20'h00000, 1'b1);
        drain();

        // Backpressure with ignored operand requests.
        out_ready = 1'b0;
        issue(20'hFFFFF, 20'hFFFFF, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_valid_seen", out_valid, 32'd1);
        repeat (3) begin
            in_a = 20'h00001; in_b = 20'h00000; in_valid = ~in_valid;
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 32'd0);
            chk("bp_out_valid", out_valid, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle", in_ready, 32'd1);
        chk("bp_queue_empty", sb_q.size(), 32'd0);
        issue(20'h00001, 20'h00001, 1'b0);
        drain();

        // Reset during RUN at idx=2.
        issue(20'hABCDE, 20'h11111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 32'd1);
        chk("midrst_out_valid", out_valid, 32'd0);
        sb_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(20'h54321, 20'h00010, 1'b1);
        drain();

        // Randomised operands with random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
        bp_en = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
